// File: rtl/sr_bank_driver_pkg.sv
// sr_bank_driver_pkg
//   Shared definitions for the SR bank driver: default parameter values,
//   FSM state encoding and a counter-width helper.
package sr_bank_driver_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_SETTLE_CYC = 1;
  localparam int DEF_RETRIES    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_WAIT  = 2'd2
  } drv_state_e;

  // Bits needed to hold 0..max_val; never less than one bit so that a
  // zero-valued parameter still yields a legal vector.
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sr_bank_driver_if.sv
// sr_bank_driver_if
//   Bundles the request handshake, the S/R pulse bus, the Q readback and the
//   status flags of the SR bank driver.
//   Ports (all members):
//     req_valid, req_data  request from control logic
//     req_ready            driver can accept
//     sr_s, sr_r           set/reset pulses to the SR flop bank
//     q_in                 Q readback from the bank
//     busy, done, err      status
//   modport slave  : the driver itself
//   modport master : everything around it (control logic plus the bank)
interface sr_bank_driver_if
  import sr_bank_driver_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic [WIDTH-1:0] sr_s;
  logic [WIDTH-1:0] sr_r;
  logic [WIDTH-1:0] q_in;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output req_valid, req_data, q_in,
    input  req_ready, sr_s, sr_r, busy, done, err
  );

  modport slave (
    input  req_valid, req_data, q_in,
    output req_ready, sr_s, sr_r, busy, done, err
  );

endinterface

// File: rtl/sr_bank_driver_pulse_gen.sv
// sr_pulse_gen
//   Registered S/R pulse pair for a bank of WIDTH SR flops.  On load it
//   registers set pulses for bits that must go 0->1 and reset pulses for bits
//   that must go 1->0; on clear both vectors return to zero.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     load        register pulses computed from target/q
//     clear       drop both pulse vectors (wins over load)
//     target      word the bank should hold
//     q           current bank readback
//     s, r        registered set/reset pulses
module sr_pulse_gen
  import sr_bank_driver_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r
);

  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] s_next;
  logic [WIDTH-1:0] r_next;

  // r_next is additionally masked with ~s_next so that S=R=1 is impossible
  // by construction, even if the two expressions were ever edited apart.
  assign diff   = target ^ q;
  assign s_next = target & diff;
  assign r_next = ~target & diff & ~s_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= '0;
      r <= '0;
    end else if (clear) begin
      s <= '0;
      r <= '0;
    end else if (load) begin
      s <= s_next;
      r <= r_next;
    end
  end

endmodule

// File: rtl/sr_bank_driver.sv
// sr_bank_driver
//   Command side of a synchronous SR flop bank.  Accepts a target word on a
//   valid/ready handshake, drives one-cycle S/R pulses, waits SETTLE_CYC
//   cycles, compares the readback and retries up to RETRIES times before
//   flagging err.  A request that already matches the bank completes at once.
//   Ports:
//     clk    clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    sr_bank_driver_if.slave: req_valid/req_ready/req_data,
//            sr_s/sr_r pulses, q_in readback, busy/done/err status
module sr_bank_driver
  import sr_bank_driver_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int RETRIES    = DEF_RETRIES
) (
  input  logic             clk,
  input  logic             rst_n,
  sr_bank_driver_if.slave  bus
);

  localparam int SW = cnt_width(SETTLE_CYC);
  localparam int RW = cnt_width(RETRIES);

  drv_state_e       state, state_next;
  logic [WIDTH-1:0] target, target_next;
  logic [SW-1:0]    settle_cnt, settle_next;
  logic [RW-1:0]    retry_cnt, retry_next;
  logic             done_q, done_next;
  logic             err_q, err_next;

  logic             pulse_load;
  logic             pulse_clear;
  logic [WIDTH-1:0] pulse_word;
  logic [WIDTH-1:0] pulse_s;
  logic [WIDTH-1:0] pulse_r;

  logic             accept;
  logic             settled;
  logic             match;

  assign accept  = bus.req_valid && (state == ST_IDLE);
  // The counter reaches zero on the edge where it currently holds one; the
  // "<=" also covers a stray zero so the FSM can never stall in WAIT.
  assign settled = (settle_cnt <= SW'(1));
  assign match   = (bus.q_in == target);

  always_comb begin
    state_next  = state;
    target_next = target;
    settle_next = settle_cnt;
    retry_next  = retry_cnt;
    done_next   = 1'b0;
    err_next    = 1'b0;
    pulse_load  = 1'b0;
    pulse_clear = 1'b0;
    pulse_word  = target;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          // target is not registered yet, so pulses come from req_data.
          target_next = bus.req_data;
          pulse_word  = bus.req_data;
          if (bus.req_data == bus.q_in) begin
            done_next = 1'b1;
          end else begin
            pulse_load = 1'b1;
            retry_next = '0;
            state_next = ST_DRIVE;
          end
        end
      end

      ST_DRIVE: begin
        pulse_clear = 1'b1;
        settle_next = SW'(SETTLE_CYC);
        state_next  = ST_WAIT;
      end

      ST_WAIT: begin
        if (!settled) begin
          settle_next = settle_cnt - SW'(1);
        end else begin
          settle_next = '0;
          if (match) begin
            done_next  = 1'b1;
            state_next = ST_IDLE;
          end else if (retry_cnt < RW'(RETRIES)) begin
            // Retry pulses come from the live readback, so an external
            // disturbance is corrected rather than re-driven blindly.
            retry_next = retry_cnt + RW'(1);
            pulse_load = 1'b1;
            state_next = ST_DRIVE;
          end else begin
            err_next   = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end

      default: begin
        pulse_clear = 1'b1;
        state_next  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      target     <= '0;
      settle_cnt <= '0;
      retry_cnt  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_next;
      target     <= target_next;
      settle_cnt <= settle_next;
      retry_cnt  <= retry_next;
      done_q     <= done_next;
      err_q      <= err_next;
    end
  end

  sr_pulse_gen #(
    .WIDTH (WIDTH)
  ) u_pulse_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (pulse_load),
    .clear  (pulse_clear),
    .target (pulse_word),
    .q      (bus.q_in),
    .s      (pulse_s),
    .r      (pulse_r)
  );

  // Ready/busy decode straight from the state register so an async reset
  // updates them without waiting for a clock edge.
  assign bus.req_ready = (state == ST_IDLE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.sr_s      = pulse_s;
  assign bus.sr_r      = pulse_r;

endmodule
